alarm_set_bank: RTL and testbench

//  Multi-channel alarm-time store and editor. Holds NUM_ALARMS alarm times (24h internal) plus enable bits.

---
 rtl/alarm_pkg.sv | 51 +++++
 rtl/key_repeat.sv | 48 ++++
 rtl/alarm_set_bank.sv | 147 ++++++++++++++
 tb/tb_alarm_set_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-time store: time word layout, field codes,
// edit FSM states and small helpers for packing and stepping time fields.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MS_MAX   = 6'd59;

  localparam logic [2:0] FLD_HOUR  = 3'b001;
  localparam logic [2:0] FLD_MIN   = 3'b010;
  localparam logic [2:0] FLD_SEC   = 3'b011;
  localparam logic [2:0] FLD_MERID = 3'b100;
  localparam logic [2:0] FLD_EN    = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  function automatic logic [TIME_W-1:0] pack_time(input time_t t);
    return {t.hour, t.min, t.sec};
  endfunction

  function automatic time_t unpack_time(input logic [TIME_W-1:0] w);
    time_t t;
    t.hour = w[TIME_W-1 -: HOUR_W];
    t.min  = w[SEC_W +: MIN_W];
    t.sec  = w[SEC_W-1:0];
    return t;
  endfunction

  // Wrap-around increment/decrement of a single field; fields never carry.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                           input logic up);
    if (up)
      return (v >= max) ? 6'd0 : v + 6'd1;
    else
      return (v == 6'd0) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns a held, debounced key level into step pulses: one on press, then
// auto-repeat after REPEAT_DELAY held cycles and every REPEAT_RATE cycles after.
module key_repeat #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CNT_W        = 16
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic KEY,
  input  logic INHIBIT,
  output logic STEP
);

  localparam logic [CNT_W-1:0] DELAY_T = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_T  = CNT_W'(REPEAT_RATE - 1);

  logic             key_d;
  logic             repeating;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic             active;

  // The counter holds the number of earlier held cycles, so the press cycle sees 0.
  assign target = repeating ? RATE_T : DELAY_T;
  assign active = KEY && !INHIBIT;
  assign STEP   = active && (!key_d || (cnt == target));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      key_d     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else begin
      key_d <= KEY;
      if (!active) begin
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (cnt == target) begin
        repeating <= 1'b1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_set_bank.sv
// Multi-channel alarm-time store with a shadow-register editor, auto-repeating
// UP/DOWN keys and a 12/24h display mux.
module alarm_set_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int CH_W         = 2,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CNT_W        = 16
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     START,
  input  logic [CH_W-1:0]          SEL_CH,
  input  logic                     EDIT_EN,
  input  logic [2:0]               FIELD,
  input  logic                     UP,
  input  logic                     DOWN,
  input  logic                     COMMIT,
  input  logic                     CANCEL,
  input  logic                     FORMAT_12,
  output logic [NUM_ALARMS*17-1:0] ALARM_TIME,
  output logic [NUM_ALARMS-1:0]    ALARM_EN,
  output logic                     EDIT_BUSY,
  output logic [CH_W-1:0]          EDIT_CH,
  output logic [17:0]              DISP_TIME
);

  import alarm_pkg::*;

  localparam logic [CH_W:0] NUM_CH = (CH_W + 1)'(NUM_ALARMS);

  state_t               state, state_nxt;
  logic [TIME_W-1:0]    store [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  time_t                shadow, shadow_nxt;
  logic                 shadow_en, shadow_en_nxt;
  logic [CH_W-1:0]      edit_ch;

  logic up_step, down_step, inhibit;
  logic sel_ok, open_edit, abort_edit, commit_edit, edit_step;

  assign inhibit = UP & DOWN;

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_up_key (
    .CLK(CLK), .RESETN(RESETN), .KEY(UP), .INHIBIT(inhibit), .STEP(up_step)
  );

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_down_key (
    .CLK(CLK), .RESETN(RESETN), .KEY(DOWN), .INHIBIT(inhibit), .STEP(down_step)
  );

  // CANCEL (or losing edit permission) takes priority over COMMIT.
  assign sel_ok      = ({1'b0, SEL_CH} < NUM_CH);
  assign open_edit   = (state == ST_IDLE) && START && EDIT_EN && sel_ok;
  assign abort_edit  = (state == ST_EDIT) && (CANCEL || !EDIT_EN);
  assign commit_edit = (state == ST_EDIT) && COMMIT && !abort_edit;
  assign edit_step   = (state == ST_EDIT) && !abort_edit && !COMMIT && (up_step || down_step);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (open_edit) state_nxt = ST_EDIT;
      ST_EDIT: if (abort_edit || commit_edit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Shadow load on open, then field edits; up_step and down_step are never both set.
  always_comb begin
    shadow_nxt    = shadow;
    shadow_en_nxt = shadow_en;
    if (open_edit) begin
      shadow_nxt    = unpack_time(store[SEL_CH]);
      shadow_en_nxt = en_q[SEL_CH];
      if (shadow_nxt.hour > HOUR_MAX) shadow_nxt.hour = '0;
    end else if (edit_step) begin
      case (FIELD)
        FLD_HOUR:  shadow_nxt.hour = HOUR_W'(wrap_step(6'(shadow.hour), 6'(HOUR_MAX), up_step));
        FLD_MIN:   shadow_nxt.min  = wrap_step(shadow.min, MS_MAX, up_step);
        FLD_SEC:   shadow_nxt.sec  = wrap_step(shadow.sec, MS_MAX, up_step);
        FLD_MERID: if (FORMAT_12)
                     shadow_nxt.hour = (shadow.hour < 5'd12) ? shadow.hour + 5'd12
                                                             : shadow.hour - 5'd12;
        FLD_EN:    shadow_en_nxt = !shadow_en;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      shadow    <= '0;
      shadow_en <= 1'b0;
      edit_ch   <= '0;
    end else begin
      shadow    <= shadow_nxt;
      shadow_en <= shadow_en_nxt;
      if (open_edit) edit_ch <= SEL_CH;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_ALARMS; i++) store[i] <= '0;
      en_q <= '0;
    end else if (commit_edit) begin
      store[edit_ch] <= pack_time(shadow);
      en_q[edit_ch]  <= shadow_en;
    end
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_out
    assign ALARM_TIME[g*TIME_W +: TIME_W] = store[g];
  end

  assign ALARM_EN  = en_q;
  assign EDIT_BUSY = (state == ST_EDIT);
  assign EDIT_CH   = edit_ch;

  time_t             disp_src;
  logic              disp_pm;
  logic [HOUR_W-1:0] disp_hour;

  // 12h view: midnight/noon hour 0 is shown as 12.
  always_comb begin
    if (state == ST_EDIT)
      disp_src = shadow;
    else if (sel_ok)
      disp_src = unpack_time(store[SEL_CH]);
    else
      disp_src = '0;
    disp_pm   = 1'b0;
    disp_hour = disp_src.hour;
    if (FORMAT_12) begin
      disp_pm = (disp_src.hour >= 5'd12);
      if (disp_pm) disp_hour = disp_src.hour - 5'd12;
      if (disp_hour == '0) disp_hour = 5'd12;
    end
    DISP_TIME = {disp_pm, disp_hour, disp_src.min, disp_src.sec};
  end

endmodule

// File: tb/tb_alarm_set_bank.sv
// Directed bench for alarm_set_bank: edit/commit/cancel, key auto-repeat,
// 12/24h display and mid-edit aborts, all against hand-computed values.
module tb_alarm_set_bank;

  localparam int NA = 4;
  localparam int CW = 2;
  localparam int RD = 500;
  localparam int RR = 100;

  logic            CLK = 1'b0;
  logic            RESETN;
  logic            START;
  logic [CW-1:0]   SEL_CH;
  logic            EDIT_EN;
  logic [2:0]      FIELD;
  logic            UP;
  logic            DOWN;
  logic            COMMIT;
  logic            CANCEL;
  logic            FORMAT_12;
  logic [NA*17-1:0] ALARM_TIME;
  logic [NA-1:0]   ALARM_EN;
  logic            EDIT_BUSY;
  logic [CW-1:0]   EDIT_CH;
  logic [17:0]     DISP_TIME;

  int errors = 0;
  int checks = 0;
  logic [16:0] mt [NA];
  logic [NA-1:0] men;

  always #5 CLK = ~CLK;

  alarm_set_bank #(
    .NUM_ALARMS(NA), .CH_W(CW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .SEL_CH(SEL_CH), .EDIT_EN(EDIT_EN),
    .FIELD(FIELD), .UP(UP), .DOWN(DOWN), .COMMIT(COMMIT), .CANCEL(CANCEL),
    .FORMAT_12(FORMAT_12), .ALARM_TIME(ALARM_TIME), .ALARM_EN(ALARM_EN),
    .EDIT_BUSY(EDIT_BUSY), .EDIT_CH(EDIT_CH), .DISP_TIME(DISP_TIME)
  );

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [17:0] dt(input int pm, input int h, input int m, input int s);
    return {1'(pm), 5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Taps a key n times: one cycle pressed, one cycle released.
  task automatic applyStimulus(input logic up, input logic dn, input int n);
    repeat (n) begin
      UP = up;
      DOWN = dn;
      tick();
      UP = 1'b0;
      DOWN = 1'b0;
      tick();
    end
  endtask

  task automatic openEdit(input logic [CW-1:0] ch);
    SEL_CH = ch;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic pulseCommit;
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  task automatic checkStore(input string tag);
    checkOutput({tag, "_time"}, ALARM_TIME, {mt[3], mt[2], mt[1], mt[0]});
    checkOutput({tag, "_en"}, ALARM_EN, men);
  endtask

  initial begin
    RESETN = 1'b0; START = 1'b0; SEL_CH = '0; EDIT_EN = 1'b1; FIELD = 3'd0;
    UP = 1'b0; DOWN = 1'b0; COMMIT = 1'b0; CANCEL = 1'b0; FORMAT_12 = 1'b0;
    for (int i = 0; i < NA; i++) mt[i] = '0;
    men = '0;
    repeat (3) tick();
    RESETN = 1'b1;
    tick();
    checkStore("reset");
    checkOutput("reset_busy", EDIT_BUSY, 1'b0);
    checkOutput("reset_ch", EDIT_CH, 2'd0);
    checkOutput("reset_disp", DISP_TIME, dt(0, 0, 0, 0));

    openEdit(2);
    checkOutput("open_busy", EDIT_BUSY, 1'b1);
    checkOutput("open_ch", EDIT_CH, 2'd2);
    FIELD = 3'b001;
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("hour_up3", DISP_TIME, dt(0, 3, 0, 0));
    pulseCommit();
    mt[2] = tm(3, 0, 0);
    checkStore("commit2");
    checkOutput("commit_busy", EDIT_BUSY, 1'b0);

    openEdit(1);
    FIELD = 3'b010;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("min_down_wrap", DISP_TIME, dt(0, 0, 59, 0));
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("min_up_wrap", DISP_TIME, dt(0, 0, 0, 0));
    FIELD = 3'b011;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("sec_down_wrap", DISP_TIME, dt(0, 0, 0, 59));
    FIELD = 3'b001;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("hour_down_wrap", DISP_TIME, dt(0, 23, 0, 59));
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("hour_up_wrap", DISP_TIME, dt(0, 0, 0, 59));
    CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    checkStore("cancel1");
    checkOutput("cancel_busy", EDIT_BUSY, 1'b0);

    openEdit(0);
    FIELD = 3'b010;
    UP = 1'b1;
    repeat (RD + 3 * RR) tick();
    UP = 1'b0;
    tick();
    checkOutput("hold_5_steps", DISP_TIME, dt(0, 0, 5, 0));

    UP = 1'b1;
    DOWN = 1'b1;
    repeat (1000) tick();
    checkOutput("both_held", DISP_TIME, dt(0, 0, 5, 0));
    DOWN = 1'b0;
    tick();
    checkOutput("release_no_step", DISP_TIME, dt(0, 0, 5, 0));
    repeat (RD - 2) tick();
    checkOutput("restart_before", DISP_TIME, dt(0, 0, 5, 0));
    tick();
    checkOutput("restart_delay", DISP_TIME, dt(0, 0, 6, 0));
    UP = 1'b0;
    tick();
    pulseCommit();
    mt[0] = tm(0, 6, 0);
    checkStore("commit0");

    openEdit(3);
    FIELD = 3'b001;
    applyStimulus(1'b1, 1'b0, 13);
    checkOutput("hour13_24h", DISP_TIME, dt(0, 13, 0, 0));
    FORMAT_12 = 1'b1;
    #1;
    checkOutput("hour13_12h", DISP_TIME, dt(1, 1, 0, 0));
    FIELD = 3'b100;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("merid_to_am", DISP_TIME, dt(0, 1, 0, 0));
    FIELD = 3'b001;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("midnight_12", DISP_TIME, dt(0, 12, 0, 0));
    FIELD = 3'b100;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("noon_12pm", DISP_TIME, dt(1, 12, 0, 0));
    FORMAT_12 = 1'b0;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("merid_24h_noop", DISP_TIME, dt(0, 12, 0, 0));
    FIELD = 3'b101;
    applyStimulus(1'b1, 1'b0, 1);
    FIELD = 3'b110;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("field_none", DISP_TIME, dt(0, 12, 0, 0));
    pulseCommit();
    mt[3] = tm(12, 0, 0);
    men = 4'b1000;
    checkStore("commit3");

    SEL_CH = 2'd3;
    FORMAT_12 = 1'b1;
    #1;
    checkOutput("idle_disp3", DISP_TIME, dt(1, 12, 0, 0));
    SEL_CH = 2'd2;
    FORMAT_12 = 1'b0;
    #1;
    checkOutput("idle_disp2", DISP_TIME, dt(0, 3, 0, 0));

    FIELD = 3'b001;
    applyStimulus(1'b1, 1'b0, 2);
    checkStore("idle_steps");
    openEdit(2);
    checkOutput("reload_shadow", DISP_TIME, dt(0, 3, 0, 0));
    SEL_CH = 2'd1;
    START = 1'b1;
    tick();
    START = 1'b0;
    checkOutput("start_in_edit", EDIT_CH, 2'd2);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("hour4", DISP_TIME, dt(0, 4, 0, 0));
    EDIT_EN = 1'b0;
    tick();
    EDIT_EN = 1'b1;
    checkOutput("editen_abort", EDIT_BUSY, 1'b0);
    checkStore("editen_abort");

    EDIT_EN = 1'b0;
    openEdit(1);
    checkOutput("start_no_en", EDIT_BUSY, 1'b0);
    EDIT_EN = 1'b1;

    openEdit(2);
    applyStimulus(1'b1, 1'b0, 1);
    COMMIT = 1'b1;
    CANCEL = 1'b1;
    tick();
    COMMIT = 1'b0;
    CANCEL = 1'b0;
    checkOutput("cc_busy", EDIT_BUSY, 1'b0);
    checkStore("commit_cancel");

    openEdit(3);
    applyStimulus(1'b0, 1'b1, 1);
    @(posedge CLK);
    #2;
    RESETN = 1'b0;
    #2;
    for (int i = 0; i < NA; i++) mt[i] = '0;
    men = '0;
    checkStore("mid_reset");
    checkOutput("mid_reset_busy", EDIT_BUSY, 1'b0);
    checkOutput("mid_reset_ch", EDIT_CH, 2'd0);
    tick();
    RESETN = 1'b1;
    tick();
    SEL_CH = 2'd3;
    #1;
    checkOutput("post_reset_disp", DISP_TIME, dt(0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
